// File: rtl/fpcvt_pkg.sv
// Shared widths and constants for the linear-to-float sample converter.
// The optional rounding stage is enabled by defining FPCVT_ROUND_EN.
package fpcvt_pkg;

  localparam int D_W   = 13;
  localparam int MAG_W = 12;
  localparam int E_W   = 3;
  localparam int F_W   = 5;
  localparam int P_W   = 4;

  localparam logic [E_W-1:0] E_MAX   = 3'd7;
  localparam logic [F_W-1:0] F_MAX   = 5'b11111;
  localparam logic [F_W-1:0] F_CARRY = 5'b10000;

  typedef struct packed {
    logic           s;
    logic [E_W-1:0] e;
    logic [F_W-1:0] f;
  } fp_code_t;

endpackage

// File: rtl/fpcvt_if.sv
// Sample/code bundle between the linear sample path and the compressed path.
interface fpcvt_if;
  import fpcvt_pkg::*;

  logic [D_W-1:0] D;
  logic           S;
  logic [E_W-1:0] E;
  logic [F_W-1:0] F;

  modport master (output D, input S, E, F);
  modport slave  (input D, output S, E, F);

endinterface

// File: rtl/fpcvt_lead_one.sv
// Priority encoder: position of the most significant set bit of the magnitude.
module fpcvt_lead_one
  import fpcvt_pkg::*;
(
  input  logic [MAG_W-1:0] mag_i,
  output logic [P_W-1:0]   pos_o,
  output logic             valid_o
);

  // Scanning upward lets the highest set bit overwrite lower ones.
  always_comb begin
    pos_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < MAG_W; i++) begin
      if (mag_i[i]) begin
        pos_o   = P_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpcvt.sv
// 13-bit two's-complement sample to 9-bit {S,E,F} float code, one-cycle latency.
// Define FPCVT_ROUND_EN for round-half-up; otherwise the significand is truncated.
module fpcvt
  import fpcvt_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  fpcvt_if.slave  bus
);

  logic             sign_d;
  logic [MAG_W-1:0] low_d;
  logic [MAG_W-1:0] mag_d;
  logic [P_W-1:0]   pos_d;
  logic             nonzero_d;
  fp_code_t         code_d;
  fp_code_t         code_q;

  assign sign_d = bus.D[D_W-1];
  assign low_d  = bus.D[MAG_W-1:0];

  // -4096 has no 12-bit magnitude, so it clamps to the largest one.
  always_comb begin
    if (!sign_d) begin
      mag_d = low_d;
    end else if (low_d == '0) begin
      mag_d = '1;
    end else begin
      mag_d = ~low_d + 1'b1;
    end
  end

  fpcvt_lead_one u_lead_one (
    .mag_i   (mag_d),
    .pos_o   (pos_d),
    .valid_o (nonzero_d)
  );

  always_comb begin
    code_d.s = sign_d;
    code_d.e = '0;
    code_d.f = mag_d[F_W-1:0];
    if (nonzero_d && (pos_d > 4'd4)) begin
      code_d.e = E_W'(pos_d - 4'd4);
      code_d.f = mag_d[pos_d -: F_W];
`ifdef FPCVT_ROUND_EN
      // A carry out of the significand bumps the exponent; at the top it clamps.
      if (mag_d[pos_d - 4'd5]) begin
        if (code_d.f != F_MAX) begin
          code_d.f = code_d.f + 1'b1;
        end else if (code_d.e != E_MAX) begin
          code_d.e = code_d.e + 1'b1;
          code_d.f = F_CARRY;
        end else begin
          code_d.f = F_MAX;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
    end else begin
      code_q <= code_d;
    end
  end

  assign bus.S = code_q.s;
  assign bus.E = code_q.e;
  assign bus.F = code_q.f;

endmodule

// File: tb/tb_fpcvt.sv
// Self-checking bench for fpcvt: directed corner cases, full sweep and random samples.
// Expected codes follow FPCVT_ROUND_EN the same way the design does.
module tb_fpcvt;
  import fpcvt_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checkCount = 0;
  int   passCount  = 0;

  always #5 clk = ~clk;

  fpcvt_if bus ();

  fpcvt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: scale the magnitude down by powers of two until it fits in 5 bits.
  function automatic logic [8:0] refModel(input int d);
    int   mag;
    int   e;
    int   q;
    logic s;
    s   = (d < 0);
    mag = s ? -d : d;
    if (mag > 4095) mag = 4095;
    if (mag < 32) return {s, 3'd0, 5'(mag)};
    e = 0;
    while ((mag >> e) >= 32) e++;
    q = mag >> e;
`ifdef FPCVT_ROUND_EN
    if (((mag >> (e - 1)) & 1) == 1) q++;
    if (q == 32) begin
      q = 16;
      e++;
    end
    if (e > 7) begin
      e = 7;
      q = 31;
    end
`endif
    return {s, 3'(e), 5'(q)};
  endfunction

  task automatic applyStimulus(input int d);
    @(negedge clk);
    bus.D = 13'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [8:0] observed,
                             input logic [8:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got S=%b E=%0d F=%b, expected S=%b E=%0d F=%b",
               tag, observed[8], observed[7:5], observed[4:0],
               expected[8], expected[7:5], expected[4:0]);
    end
  endtask

  function automatic logic [8:0] observedCode();
    return {bus.S, bus.E, bus.F};
  endfunction

  int         dirD     [14] = '{0, 1, 31, 32, 33, 63, 3967, 3968, 4032, 4095,
                                 -4096, -1, -33, -63};
`ifdef FPCVT_ROUND_EN
  logic [8:0] dirExp   [14] = '{9'b0_000_00000, 9'b0_000_00001, 9'b0_000_11111,
                                 9'b0_001_10000, 9'b0_001_10001, 9'b0_010_10000,
                                 9'b0_111_11111, 9'b0_111_11111, 9'b0_111_11111,
                                 9'b0_111_11111, 9'b1_111_11111, 9'b1_000_00001,
                                 9'b1_001_10001, 9'b1_010_10000};
`else
  logic [8:0] dirExp   [14] = '{9'b0_000_00000, 9'b0_000_00001, 9'b0_000_11111,
                                 9'b0_001_10000, 9'b0_001_10000, 9'b0_001_11111,
                                 9'b0_111_11110, 9'b0_111_11111, 9'b0_111_11111,
                                 9'b0_111_11111, 9'b1_111_11111, 9'b1_000_00001,
                                 9'b1_001_10000, 9'b1_001_11111};
`endif

  initial begin
    int d;
    rst_n = 1'b0;
    bus.D = 13'h0ABC;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset hold", observedCode(), 9'b0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("first after reset", observedCode(), refModel(2748));

    foreach (dirD[i]) begin
      applyStimulus(dirD[i]);
      checkOutput($sformatf("directed D=%0d", dirD[i]), observedCode(), dirExp[i]);
    end

    // Asynchronous clear between edges, then recovery on the next edge.
    applyStimulus(4095);
    checkOutput("before mid reset", observedCode(), refModel(4095));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-stream reset", observedCode(), 9'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(-33);
    checkOutput("after mid reset", observedCode(), refModel(-33));

    for (int i = 0; i < 8192; i++) begin
      d = i - 4096;
      applyStimulus(d);
      checkOutput($sformatf("sweep D=%0d", d), observedCode(), refModel(d));
    end

    for (int i = 0; i < 500; i++) begin
      d = int'($urandom_range(8191)) - 4096;
      applyStimulus(d);
      checkOutput($sformatf("random D=%0d", d), observedCode(), refModel(d));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
